// File: rtl/elevator_pkg.sv
// ============================================================================
// elevator_pkg : shared floor codes, widths and sequencer state encoding
// Revision     : 1.0
// ============================================================================
`default_nettype none

package elevator_pkg;

   localparam int ADDR_W  = 8;
   localparam int FLOOR_W = 2;
   localparam int TICK_W  = 16;

   localparam logic [FLOOR_W-1:0] FLOOR_M1 = 2'b00;
   localparam logic [FLOOR_W-1:0] FLOOR_1  = 2'b01;
   localparam logic [FLOOR_W-1:0] FLOOR_2  = 2'b10;
   localparam logic [FLOOR_W-1:0] FLOOR_3  = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      MOVE   = 3'd2,
      DOOR   = 3'd3,
      NEXT   = 3'd4,
      FINISH = 3'd5
   } state_e;

endpackage

`default_nettype wire

// File: rtl/tick_timer.sv
// ============================================================================
// tick_timer : loadable down-counter, terminal count flagged at zero
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tick_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign tc_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/elevator_dispatch_ctrl.sv
// ============================================================================
// elevator_dispatch_ctrl : walks the destination queue ROM, drives motor/door
// Optional emergency stop input enabled by macro ELEVATOR_ESTOP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module elevator_dispatch_ctrl
   import elevator_pkg::*;
#(
   parameter int                 QUEUE_LEN   = 10,
   parameter int                 FLOOR_TICKS = 4,
   parameter int                 DOOR_TICKS  = 3,
   parameter logic [FLOOR_W-1:0] HOME_FLOOR  = 2'b01
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
`ifdef ELEVATOR_ESTOP_EN
   input  logic               estop,
`endif
   output logic [ADDR_W-1:0]  queue_addr,
   input  logic [23:0]        queue_dest,
   output logic [FLOOR_W-1:0] floor_cur,
   output logic               motor_up,
   output logic               motor_down,
   output logic               door_open,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  trip_count
);

   localparam logic [TICK_W-1:0] c_FLOOR_LOAD = TICK_W'(FLOOR_TICKS - 1);
   localparam logic [TICK_W-1:0] c_DOOR_LOAD  = TICK_W'(DOOR_TICKS - 1);
   localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(QUEUE_LEN - 1);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d, trip_q, trip_d;
   logic [FLOOR_W-1:0]   floor_q, floor_d, dest_q, dest_d;
   logic                 up_q, up_d, dn_q, dn_d, door_q, door_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic                 w_hold, w_tc, w_tmr_load, w_tmr_en;
   logic [TICK_W-1:0]    w_tmr_val;
   logic                 w_unused_dest;

`ifdef ELEVATOR_ESTOP_EN
   assign w_hold = estop;
`else
   assign w_hold = 1'b0;
`endif

   assign w_unused_dest = ^queue_dest[23:FLOOR_W];
   assign w_tmr_en      = ((state_q == MOVE) || (state_q == DOOR)) && !w_hold;

   // One timer serves both travel and door intervals; the load value is muxed.
   tick_timer #(.WIDTH(TICK_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (w_tmr_load),
      .load_val_i (w_tmr_val),
      .en_i       (w_tmr_en),
      .tc_o       (w_tc)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      trip_d     = trip_q;
      floor_d    = floor_q;
      dest_d     = dest_q;
      w_tmr_load = 1'b0;
      w_tmr_val  = c_FLOOR_LOAD;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               addr_d  = '0;
               trip_d  = '0;
            end
         end
         FETCH: begin
            if (!w_hold) begin
               dest_d     = queue_dest[FLOOR_W-1:0];
               w_tmr_load = 1'b1;
               if (dest_d == floor_q) begin
                  state_d   = DOOR;
                  w_tmr_val = c_DOOR_LOAD;
               end else begin
                  state_d = MOVE;
               end
            end
         end
         MOVE: begin
            if (!w_hold && w_tc) begin
               floor_d    = (dest_q > floor_q) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
               w_tmr_load = 1'b1;
               if (floor_d == dest_q) begin
                  state_d   = DOOR;
                  w_tmr_val = c_DOOR_LOAD;
               end
            end
         end
         DOOR: begin
            if (!w_hold && w_tc) state_d = NEXT;
         end
         NEXT: begin
            if (!w_hold) begin
               trip_d = trip_q + ADDR_W'(1);
               if (addr_q == c_LAST_ADDR) begin
                  state_d = FINISH;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = FETCH;
               end
            end
         end
         FINISH: begin
            addr_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from next-state values so they land in flops
      up_d   = (state_d == MOVE) && !w_hold && (dest_d > floor_d);
      dn_d   = (state_d == MOVE) && !w_hold && (dest_d < floor_d);
      door_d = (state_d == DOOR);
      busy_d = (state_d != IDLE);
      done_d = (state_d == FINISH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         trip_q  <= '0;
         floor_q <= HOME_FLOOR;
         dest_q  <= HOME_FLOOR;
         up_q    <= 1'b0;
         dn_q    <= 1'b0;
         door_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         trip_q  <= trip_d;
         floor_q <= floor_d;
         dest_q  <= dest_d;
         up_q    <= up_d;
         dn_q    <= dn_d;
         door_q  <= door_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign queue_addr = addr_q;
   assign trip_count = trip_q;
   assign floor_cur  = floor_q;
   assign motor_up   = up_q;
   assign motor_down = dn_q;
   assign door_open  = door_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_elevator_dispatch_ctrl.sv
// ============================================================================
// tb_elevator_dispatch_ctrl : table-driven runs with per-entry scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_elevator_dispatch_ctrl;
   import elevator_pkg::*;

   localparam int QLEN = 10;
   localparam int FT   = 4;
   localparam int DT   = 3;

   typedef struct { logic [1:0] dest; int up; int dn; } vec_t;
   typedef struct { logic [1:0] floor; int up; int dn; int door; logic [7:0] trip; } rec_t;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [7:0] queue_addr, trip_count;
   logic [23:0] queue_dest;
   logic [1:0] floor_cur;
   logic       motor_up, motor_down, door_open, busy, done;
`ifdef ELEVATOR_ESTOP_EN
   logic       estop = 1'b0;
`endif

   logic [1:0] rom [0:255];
   assign queue_dest = {22'h2A5A5A, rom[queue_addr]};

   elevator_dispatch_ctrl #(
      .QUEUE_LEN(QLEN), .FLOOR_TICKS(FT), .DOOR_TICKS(DT), .HOME_FLOOR(2'b01)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef ELEVATOR_ESTOP_EN
      .estop(estop),
`endif
      .queue_addr(queue_addr), .queue_dest(queue_dest), .floor_cur(floor_cur),
      .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
      .busy(busy), .done(done), .trip_count(trip_count)
   );

   always #5 clk = ~clk;

   vec_t       tv [20];
   rec_t       exp_q[$], obs_q[$];
   logic [1:0] flog_q[$], eflog_q[$];
   int         nchk = 0, nbad = 0;
   bit         excl_bad = 1'b0;

   // Monitor: accumulates motion/door cycles per entry, closes a record on door release
   int   a_up, a_dn, a_door;
   logic door_prev;
   logic [1:0] floor_prev;
   always @(negedge clk) begin
      if (reset) begin
         a_up = 0; a_dn = 0; a_door = 0; door_prev = 1'b0; floor_prev = floor_cur;
      end else begin
         if ((motor_up && motor_down) || (door_open && (motor_up || motor_down))) excl_bad = 1'b1;
         if (floor_cur != floor_prev) flog_q.push_back(floor_cur);
         floor_prev = floor_cur;
         if (motor_up)   a_up++;
         if (motor_down) a_dn++;
         if (door_open)  a_door++;
         if (door_prev && !door_open) begin
            obs_q.push_back('{floor_cur, a_up, a_dn, a_door, trip_count});
            a_up = 0; a_dn = 0; a_door = 0;
         end
         door_prev = door_open;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      nchk++;
      if (act !== expv) begin
         nbad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   initial begin
      int         exp_cyc, cyc, ndone, n;
      logic [1:0] f;
      rec_t       e, o;

      tv[0] = '{2'b10, 4, 0};  tv[1] = '{2'b01, 0, 4};  tv[2] = '{2'b11, 8, 0};
      tv[3] = '{2'b00, 0, 12}; tv[4] = '{2'b01, 4, 0};  tv[5] = '{2'b11, 8, 0};
      tv[6] = '{2'b00, 0, 12}; tv[7] = '{2'b10, 8, 0};  tv[8] = '{2'b11, 4, 0};
      tv[9] = '{2'b01, 0, 8};
      for (int i = 10; i < 20; i++) tv[i] = '{2'b01, 0, 0};
      for (int i = 0; i < 256; i++) rom[i] = 2'b00;

      reset = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_addr", queue_addr, 0);
      chk("rst_floor", floor_cur, 1);
      chk("rst_up", motor_up, 0);
      chk("rst_down", motor_down, 0);
      chk("rst_door", door_open, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_trip", trip_count, 0);
      reset = 1'b0;
      @(negedge clk);

      f = 2'b01;
      for (int r = 0; r < 2; r++) begin
         exp_q.delete(); obs_q.delete(); flog_q.delete(); eflog_q.delete();
         exp_cyc = 1;
         for (int i = 0; i < QLEN; i++) begin
            rom[i] = tv[r*QLEN+i].dest;
            exp_q.push_back('{tv[r*QLEN+i].dest, tv[r*QLEN+i].up, tv[r*QLEN+i].dn, DT, 8'(i)});
            exp_cyc += 1 + tv[r*QLEN+i].up + tv[r*QLEN+i].dn + DT + 1;
            while (f != tv[r*QLEN+i].dest) begin
               f = (tv[r*QLEN+i].dest > f) ? f + 2'd1 : f - 2'd1;
               eflog_q.push_back(f);
            end
         end

         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("fetch_busy", busy, 1);
         chk("fetch_motor", {motor_up, motor_down}, 0);
         chk("fetch_door", door_open, 0);
         cyc = 1; ndone = 0;
         while (busy && cyc < 2000) begin
            @(negedge clk);
            if (cyc == 1) begin
               chk("first_up", motor_up, tv[r*QLEN].up > 0);
               chk("first_door", door_open, (tv[r*QLEN].up + tv[r*QLEN].dn) == 0);
            end
            start = (cyc == 30);
            if (busy) cyc++;
            if (done) ndone++;
         end
         start = 1'b0;
         chk("busy_cycles", cyc, exp_cyc);
         chk("done_pulses", ndone, 1);
         chk("end_trip", trip_count, QLEN);
         chk("end_addr", queue_addr, 0);
         chk("end_floor", floor_cur, tv[r*QLEN+QLEN-1].dest);
         chk("end_done", done, 0);

         chk("entry_count", obs_q.size(), exp_q.size());
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk("entry_floor", o.floor, e.floor);
            chk("entry_up", o.up, e.up);
            chk("entry_down", o.dn, e.dn);
            chk("entry_door", o.door, e.door);
            chk("entry_trip", o.trip, e.trip);
         end
         chk("floor_steps", flog_q.size(), eflog_q.size());
         while (eflog_q.size() > 0 && flog_q.size() > 0)
            chk("floor_step", flog_q.pop_front(), eflog_q.pop_front());
      end

      // Reset in the middle of a two-floor climb
      rom[0] = 2'b11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (floor_cur != 2'b10 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("midmove_reached", n < 100, 1);
      chk("midmove_up", motor_up, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_motor", {motor_up, motor_down}, 0);
      chk("abort_floor", floor_cur, 1);
      chk("abort_addr", queue_addr, 0);
      chk("abort_door", door_open, 0);
      repeat (3) @(negedge clk);
      chk("abort_stays_idle", busy, 0);
      chk("exclusive_outputs", excl_bad, 0);

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/elevator_dispatch_ctrl.md
Name: elevator_dispatch_ctrl

Overview:
- Sequencer for the external-destination queue ROM (8-bit address in, floor code out).
- Walks the queue address by address and latches each destination. Drives motor up/down one floor per FLOOR_TICKS, then holds the door open for DOOR_TICKS.
- Sits between the queue ROM and the car motor/door drivers; owns the current-floor register.

Parameters:
- QUEUE_LEN, 10, number of queue entries visited per run (1..256).
- FLOOR_TICKS, 4, clk cycles to travel one floor (>=1).
- DOOR_TICKS, 3, clk cycles the door stays open (>=1).
- HOME_FLOOR, 2'b01, floor code loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; starts a run when idle.
- queue_addr  out  8  address to queue ROM.
- queue_dest  in  24  ROM data; only [1:0] used (00=-1, 01=1, 10=2, 11=3; code order = floor order).
- floor_cur  out  2  current floor code.
- motor_up  out  1  car moving up.
- motor_down  out  1  car moving down.
- door_open  out  1  door open.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- trip_count  out  8  entries served this run.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, queue_addr=0, floor_cur=HOME_FLOOR, all other outputs 0. Reset mid-run aborts at once and does not drive the floor back to home by motion; the register is simply reloaded.
- States:
  - IDLE
  - FETCH
  - MOVE
  - DOOR
  - NEXT
  - FINISH
- IDLE: busy=0. start=1 -> FETCH, queue_addr=0, trip_count=0. start in any other state is ignored.
- FETCH (1 cycle): latch dest=queue_dest[1:0]. dest==floor_cur -> DOOR; otherwise -> MOVE.
- MOVE: motor_up=(dest>floor_cur) or motor_down=(dest<floor_cur), never both.
  - Tick counter runs 0..FLOOR_TICKS-1.
  - At terminal count: floor_cur += or -= 1 (2-bit, no wrap possible since dest is in range) and counter clears.
  - If the new floor equals dest, go to DOOR next cycle with motor outputs low.
- DOOR: door_open=1 for exactly DOOR_TICKS cycles, then NEXT. Motors are 0.
- NEXT (1 cycle): trip_count+=1.
  - queue_addr==QUEUE_LEN-1 -> FINISH.
  - Otherwise queue_addr+=1, -> FETCH.
- FINISH (1 cycle): done=1, queue_addr=0, -> IDLE. floor_cur is retained.
- busy=1 in FETCH..FINISH inclusive.
- Latency per entry: 1 (FETCH) + |dest-floor|*FLOOR_TICKS + DOOR_TICKS + 1 (NEXT) cycles.
- Outputs are registered; motor and door outputs are mutually exclusive in all states.
- Queue address wrap: counter is 8-bit. QUEUE_LEN=256 terminates at 255 without overflow.

Optional Feature:
- Macro: ELEVATOR_ESTOP_EN.
- With it defined: adds input estop (1 bit).
- While estop=1 in MOVE or DOOR:
  - tick counters freeze;
  - motor_up/motor_down are forced to 0;
  - door_open is held at its current value;
  - state holds.
- On release, the block resumes the same count.
- estop in other states delays the transition out of FETCH/NEXT by the same hold.
- Without it defined: no estop port; behaviour as above.

Decomposition:
- Shared package elevator_pkg holds:
  - floor code constants FLOOR_M1=2'b00, FLOOR_1=2'b01, FLOOR_2=2'b10, FLOOR_3=2'b11;
  - state enum typedef;
  - width constants ADDR_W=8, FLOOR_W=2.
- One natural sub-module: tick_timer, a load/enable/terminal-count down-counter. It is instantiated for travel and door timing, or shared with a mux on the load value.

Test Plan:
- Reset then start, ROM[0]=10, from floor 01 -> FETCH 1 cycle; motor_up high 4 cycles; floor_cur=10; door_open high 3 cycles; trip_count=1 at NEXT.
- Entry equal to current floor (floor 01, dest 01) -> no motor activity; door_open 3 cycles directly after FETCH.
- Full 10-entry sequence 10,01,11,00,01,11,00,10,11,01 from 01 -> done pulses once; trip_count=10; final floor_cur=01; queue_addr back to 0; total cycle count matches the latency formula.
- Long descent 11->00 -> motor_down high for 12 consecutive cycles; floor_cur steps 10, 01, 00.
- reset asserted mid-MOVE -> next cycle state IDLE, motors 0, floor_cur=01, busy=0; start pulse during busy is ignored.
- (ELEVATOR_ESTOP_EN) estop for 5 cycles mid-MOVE -> motors 0 during hold; total MOVE time extended by exactly 5 cycles.
